// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          OPCODE_LSB = 4;
    localparam int          OPCODE_MSB = 6;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues one imem request at a time,
// hands fetched words to decode, and squashes wrong-path fetches on redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [2:0]  if_opcode,
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;       // address of the current/next request
    logic [31:0]  tgt_q, tgt_d;     // redirect target parked while draining a stale request
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic [31:0]  br_pc;

    assign br_pc = word_align(br_target);

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    // Next-state and next-PC selection; a redirect outranks every other event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        unique case (state_q)
            IDLE: begin
                state_d = WAIT;
                if (br_taken) pc_d = br_pc;
            end
            WAIT: begin
                if (br_taken) begin
                    if (imem_rvalid) begin
                        // Request already completed: drop its data, refetch at target.
                        pc_d = br_pc;
                    end else begin
                        // Request still in flight: keep address stable until it returns.
                        tgt_d   = br_pc;
                        state_d = DROP;
                    end
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    ifpc_d  = pc_q;
                    pc_d    = pc_q + PC_STEP;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (br_taken) begin
                    pc_d    = br_pc;
                    state_d = WAIT;
                end else if (id_ready) begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (br_taken) tgt_d = br_pc;
                if (imem_rvalid) begin
                    pc_d    = br_taken ? br_pc : tgt_q;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The outstanding request's address is pc_q in both WAIT and DROP.
    assign imem_req  = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == VALID);
    assign if_pc     = ifpc_q;
    assign if_instr  = instr_q;
    assign if_opcode = instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32 core: owns the program counter, issues one instruction-memory request at a time, and presents the fetched word to decode with a valid/ready handshake. It sits directly upstream of the control unit. It extracts the 3-bit major-opcode field that the control unit decodes into Branch/MemRead/MemToReg/ALUOp/MemWrite/ALUSrc/RegWrite. It accepts branch redirects from execute and squashes wrong-path fetches.

## Interface
- RESET_PC, default 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid; held high until imem_rvalid.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high.
- imem_rvalid  in  1  read data valid; may assert in the same cycle as imem_req, or any later cycle.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- if_valid  out  1  fetched instruction available to decode.
- id_ready  in  1  decode accepts; transfer happens when if_valid and id_ready are both 1.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- if_opcode  out  3  if_instr[6:4]; control-unit input (0 load, 2 store, 3 R-type, 6 branch).
- br_taken  in  1  redirect pulse from execute (Branch AND ALU condition).
- br_target  in  32  redirect PC; bits [1:0] forced to 0 internally.

## Operation
- States: IDLE, WAIT, VALID, DROP.
- Reset (async, any state): pc=RESET_PC, state=IDLE. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_opcode=0.
- IDLE: go to WAIT. imem_req is asserted from the next cycle.
- WAIT: imem_req=1, imem_addr=pc.
  - On imem_rvalid: register if_instr=imem_rdata and if_pc=pc; set pc=pc+4; go to VALID.
- VALID: if_valid=1; if_instr, if_pc and if_opcode are held stable until the handshake.
  - On handshake: go to WAIT (next request next cycle).
- DROP: imem_req stays 1 with the old address until imem_rvalid. On rvalid: discard data, set pc=latched target, go to WAIT.
- br_taken has priority over every other event:
  - IDLE or VALID: pc=target, if_valid=0 next cycle, go to WAIT. A same-cycle handshake is still counted as a transfer, but it is wrong-path; decode squashes it.
  - WAIT with imem_rvalid in the same cycle: discard data, pc=target, stay in WAIT.
  - WAIT without imem_rvalid: latch target, go to DROP.
  - DROP: overwrite the latched target with the new one.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- if_opcode is combinational from the if_instr register.

## Timing
- Minimum fetch latency: request cycle to if_valid is 1 cycle, with zero-wait memory (rvalid in the request cycle).
- Maximum throughput: one instruction per 2 cycles (VALID → WAIT bubble).
- Redirect to first target request:
  - 1 cycle from IDLE, VALID, or WAIT with rvalid.
  - 1 cycle after the outstanding rvalid from DROP.
- imem_req never drops before rvalid; imem_addr never changes while imem_req=1.
- At most one request is outstanding at any time.
- if_valid never deasserts without a handshake, except on br_taken or reset.
- Reset mid-request: the outstanding transaction is abandoned. Memory must ignore it: the environment pulses reset on both sides together.

## Structure
- Shared package (fetch_pkg): state enum (IDLE/WAIT/VALID/DROP), NOP_INSTR=32'h0000_0013, OPCODE_LSB=4, OPCODE_MSB=6, PC_STEP=4.
- Single module. No sub-module needed; the PC register with its next-PC mux stays inline.

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory, id_ready=1 → imem_addr sequence 0x100, 0x104, 0x108; if_pc matches each, one transfer every 2 cycles.
- Memory returns 0x00002083 (lw) with 3 wait cycles → imem_req high 4 cycles with stable addr; if_valid=1 the cycle after rvalid; if_opcode=0.
- id_ready=0 for 5 cycles while if_valid=1 → if_instr and if_pc are unchanged and no new imem_req is issued; fetch resumes one cycle after id_ready=1.
- br_taken with br_target=0x203 during WAIT, rvalid 2 cycles later → state DROP, old data discarded, next imem_addr=0x200, no if_valid for the old word.
- br_taken in VALID in the same cycle as the handshake → if_valid=0 next cycle; next request at the target address.
- PC=0xFFFF_FFFC fetch completes → next imem_addr=0x0000_0000. rst_n asserted mid-WAIT → all outputs take reset values immediately (asynchronous).
